// File: rtl/cosmac_bus_pkg.sv
`default_nettype none
// ============================================================================
// cosmac_bus_pkg -- shared state and phase definitions for the COSMAC master
// Rev 1.0
// ============================================================================
package cosmac_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [2:0] PH_MA_LO = 3'd2;
    localparam logic [2:0] PH_WDATA = 3'd3;
    localparam logic [2:0] PH_MWR   = 3'd5;
    localparam logic [2:0] PH_TPB   = 3'd6;
    localparam logic [2:0] PH_LAST  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/cosmac_bus_master_if.sv
`default_nettype none
// ============================================================================
// cosmac_bus_master_if -- local request/response port plus COSMAC bus pins
// Rev 1.0
// ============================================================================
interface cosmac_bus_master_if;

    logic        xclk;
    logic        nwait;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        tpa;
    logic        tpb;
    logic [7:0]  ma;
    logic        nmrd;
    logic        nmwr;
    logic        db_oe;
    logic [7:0]  db_do;
    logic [7:0]  db_di;
    logic        busy;

    modport master (
        input  xclk, nwait, clr, req_valid, req_we, req_addr, req_wdata, db_di,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output tpa, tpb, ma, nmrd, nmwr, db_oe, db_do, busy
    );

    modport slave (
        output xclk, nwait, clr, req_valid, req_we, req_addr, req_wdata, db_di,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  tpa, tpb, ma, nmrd, nmwr, db_oe, db_do, busy
    );

endinterface
`default_nettype wire

// File: rtl/cosmac_sync.sv
`default_nettype none
// ============================================================================
// cosmac_sync -- multi-flop synchronizer with rising-edge detect
// Rev 1.0
// ============================================================================
module cosmac_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  wire  clk,
    input  wire  resetn,
    input  wire  d_i,
    output logic q_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/cosmac_bus_master.sv
`default_nettype none
// ============================================================================
// cosmac_bus_master -- 1802-style initiator: one request -> one 8-phase cycle
// Rev 1.0
// ============================================================================
module cosmac_bus_master
    import cosmac_bus_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int WAIT_TIMEOUT = 1024
) (
    input wire                  clk,
    input wire                  resetn,
    cosmac_bus_master_if.master bus
);

    localparam int            CW          = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CW-1:0] C_WCNT_LAST = CW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    logic w_xclk_rise, w_xclk_lvl, w_nwait, w_nwait_rise, w_clr, w_clr_rise;
    logic w_unused;

    cosmac_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_xclk (
        .clk(clk), .resetn(resetn), .d_i(bus.xclk), .q_o(w_xclk_lvl), .rise_o(w_xclk_rise));
    cosmac_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nwait (
        .clk(clk), .resetn(resetn), .d_i(bus.nwait), .q_o(w_nwait), .rise_o(w_nwait_rise));
    cosmac_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clr (
        .clk(clk), .resetn(resetn), .d_i(bus.clr), .q_o(w_clr), .rise_o(w_clr_rise));

    assign w_unused = &{1'b0, w_xclk_lvl, w_nwait_rise, w_clr_rise};

    state_t        state_q, state_d;
    logic [2:0]    ph_q, ph_d, w_ph_nxt;
    logic          we_q, we_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d, ma_q, ma_d, db_do_q, db_do_d;
    logic          tpa_q, tpa_d, tpb_q, tpb_d, nmrd_q, nmrd_d, nmwr_q, nmwr_d;
    logic          db_oe_q, db_oe_d, busy_q, busy_d;
    logic          w_tick, w_timeout, w_abort;

    // A tick is lost, not deferred, when nwait is low at the xclk edge: that is the freeze.
    assign w_tick    = w_xclk_rise & w_nwait;
    assign w_timeout = (WAIT_TIMEOUT != 0) && (state_q == ST_RUN) && !w_nwait &&
                       (wcnt_q == C_WCNT_LAST);
    assign w_abort   = (state_q != ST_IDLE) && (!w_clr || w_timeout);
    assign w_ph_nxt  = ph_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wcnt_d      = '0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        tpa_d       = tpa_q;
        tpb_d       = tpb_q;
        ma_d        = ma_q;
        nmrd_d      = nmrd_q;
        nmwr_d      = nmwr_q;
        db_oe_d     = db_oe_q;
        db_do_d     = db_do_q;

        if (state_q == ST_RUN && !w_nwait) begin
            wcnt_d = wcnt_q + CW'(1);
        end

        if (w_abort) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            tpa_d       = 1'b0;
            tpb_d       = 1'b0;
            ma_d        = '0;
            nmrd_d      = 1'b1;
            nmwr_d      = 1'b1;
            db_oe_d     = 1'b0;
            db_do_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_ready_q && bus.req_valid) begin
                        we_d    = bus.req_we;
                        addr_d  = bus.req_addr;
                        wdata_d = bus.req_wdata;
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (w_tick) begin
                        state_d = ST_RUN;
                        ph_d    = '0;
                        ma_d    = addr_q[15:8];
                        tpa_d   = 1'b1;
                        nmrd_d  = we_q;
                    end
                end
                ST_RUN: begin
                    if (w_tick && ph_q == PH_LAST) begin
                        state_d     = ST_IDLE;
                        nmrd_d      = 1'b1;
                        db_oe_d     = 1'b0;
                        rsp_valid_d = 1'b1;
                    end else if (w_tick) begin
                        ph_d = w_ph_nxt;
                        case (w_ph_nxt)
                            PH_MA_LO: begin
                                tpa_d = 1'b0;
                                ma_d  = addr_q[7:0];
                            end
                            PH_WDATA: begin
                                if (we_q) begin
                                    db_oe_d = 1'b1;
                                    db_do_d = wdata_q;
                                end
                            end
                            PH_MWR: begin
                                if (we_q) nmwr_d = 1'b0;
                            end
                            PH_TPB: tpb_d = 1'b1;
                            PH_LAST: begin
                                nmwr_d = 1'b1;
                                tpb_d  = 1'b0;
                                if (!we_q) rsp_rdata_d = bus.db_di;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        req_ready_d = (state_d == ST_IDLE) && w_clr;
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            ph_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wcnt_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            tpa_q       <= 1'b0;
            tpb_q       <= 1'b0;
            ma_q        <= '0;
            nmrd_q      <= 1'b1;
            nmwr_q      <= 1'b1;
            db_oe_q     <= 1'b0;
            db_do_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wcnt_q      <= wcnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            tpa_q       <= tpa_d;
            tpb_q       <= tpb_d;
            ma_q        <= ma_d;
            nmrd_q      <= nmrd_d;
            nmwr_q      <= nmwr_d;
            db_oe_q     <= db_oe_d;
            db_do_q     <= db_do_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.tpa       = tpa_q;
    assign bus.tpb       = tpb_q;
    assign bus.ma        = ma_q;
    assign bus.nmrd      = nmrd_q;
    assign bus.nmwr      = nmwr_q;
    assign bus.db_oe     = db_oe_q;
    assign bus.db_do     = db_do_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cosmac_bus_master.sv
`default_nettype none
// ============================================================================
// tb_cosmac_bus_master -- randomized bus-cycle checks against a phase-table model
// Rev 1.0
// ============================================================================
module tb_cosmac_bus_master;

    localparam int SYNC_STAGES  = 2;
    localparam int WAIT_TIMEOUT = 64;

    logic clk = 1'b0;
    logic resetn;

    cosmac_bus_master_if bus ();

    cosmac_bus_master #(
        .SYNC_STAGES (SYNC_STAGES),
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // xclk is eight clk periods long and offset so its edges never coincide with clk.
    initial begin
        bus.xclk = 1'b0;
        #3;
        forever #40 bus.xclk = ~bus.xclk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [7:0]  mem [0:65535];
    logic [7:0]  hi_lat;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_tup[$];
    int          exp_len[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bus_tuple();
        return {11'd0, bus.ma, (bus.db_oe ? bus.db_do : 8'h00),
                bus.tpa, bus.tpb, bus.nmrd, bus.nmwr, bus.db_oe};
    endfunction

    // Expected pin pattern per phase, merged into runs of identical values (8 clk per phase).
    task automatic build_exp(input bit we, input logic [15:0] a, input logic [7:0] wd);
        logic [31:0] t;
        logic        oe, tpa, tpb, nmwr, nmrd;
        logic [7:0]  m;
        exp_tup.delete();
        exp_len.delete();
        for (int ph = 0; ph < 8; ph++) begin
            tpa  = (ph < 2);
            m    = tpa ? a[15:8] : a[7:0];
            oe   = we && (ph >= 3);
            tpb  = (ph == 6);
            nmwr = !(we && (ph == 5 || ph == 6));
            nmrd = we;
            t    = {11'd0, m, (oe ? wd : 8'h00), tpa, tpb, nmrd, nmwr, oe};
            if (exp_tup.size() > 0 && exp_tup[exp_tup.size()-1] == t) begin
                exp_len[exp_len.size()-1] += 8;
            end else begin
                exp_tup.push_back(t);
                exp_len.push_back(8);
            end
        end
    endtask

    task automatic slave_step();
        if (bus.tpa) hi_lat = bus.ma;
        if (!bus.nmwr && bus.db_oe) mem[{hi_lat, bus.ma}] = bus.db_do;
        bus.db_di = !bus.nmrd ? mem[{hi_lat, bus.ma}] : 8'($urandom);
    endtask

    // act: 0 plain, 1 nwait stall in ph4, 2 nwait held from ph3, 3 clr low in ph5, 4 reset in ph6
    task automatic run_cycle(input bit we, input logic [15:0] a, input logic [7:0] wd, input int act);
        logic [31:0] got_t[$];
        int          got_l[$];
        logic [7:0]  exp_rd;
        int          idx, c_trig, c_done, k, total;
        bit          started, done, flag_a, flag_b;
        exp_rd  = mem[a];
        build_exp(we, a, wd);
        idx     = 0;
        c_trig  = 0;
        c_done  = 0;
        started = 1'b0;
        done    = 1'b0;

        @(negedge clk);
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;

        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            slave_step();
            if (bus.rsp_valid) begin
                done   = 1'b1;
                c_done = c;
            end else if (bus.tpa || started) begin
                started = 1'b1;
                if (got_t.size() > 0 && got_t[got_t.size()-1] == bus_tuple()) begin
                    got_l[got_l.size()-1]++;
                end else begin
                    got_t.push_back(bus_tuple());
                    got_l.push_back(1);
                end
                case (act)
                    1: begin
                        if (idx == 34) bus.nwait = 1'b0;
                        if (idx == 54) bus.nwait = 1'b1;
                    end
                    2: if (idx == 26) begin bus.nwait = 1'b0; c_trig = c; end
                    3: if (idx == 42) begin bus.clr = 1'b0; c_trig = c; end
                    4: if (idx == 50) begin
                        check("rst_pre_tpb", 32'(bus.tpb), 32'd1);
                        resetn = 1'b0;
                        #1;
                        check("rst_async", 32'({bus.tpa, bus.tpb, bus.nmrd, bus.nmwr, bus.db_oe, bus.busy}),
                              32'b001100);
                        flag_a = 1'b0;
                        repeat (6) begin
                            @(negedge clk);
                            flag_a |= bus.rsp_valid;
                        end
                        check("rst_no_rsp", 32'(flag_a), 32'd0);
                        resetn = 1'b1;
                        done   = 1'b1;
                    end
                    default: ;
                endcase
                idx++;
            end
        end
        check("rsp_seen", 32'(done), 32'd1);

        if (act == 0 || act == 1) begin
            check("rsp_err", 32'(bus.rsp_err), 32'd0);
            if (!we) check($sformatf("rdata@%04h", a), 32'(bus.rsp_rdata), 32'(exp_rd));
            else     check($sformatf("wmem@%04h", a), 32'(mem[a]), 32'(wd));
            check("end_pins", 32'({bus.tpa, bus.tpb, bus.nmrd, bus.nmwr, bus.db_oe, bus.busy}), 32'b001100);
            check("seg_count", 32'(got_t.size()), 32'(exp_tup.size()));
            total = 0;
            for (int i = 0; i < got_t.size() && i < exp_tup.size(); i++) begin
                check($sformatf("seg%0d_pins", i), got_t[i], exp_tup[i]);
                if (act == 0) check($sformatf("seg%0d_len", i), 32'(got_l[i]), 32'(exp_len[i]));
                total += got_l[i];
            end
            if (act == 1) check("stall_len_ok", 32'(total >= 80 && total <= 96), 32'd1);
        end else if (act == 2) begin
            check("to_err", 32'(bus.rsp_err), 32'd1);
            check("to_delay_ok", 32'(c_done - c_trig >= 62 && c_done - c_trig <= 70), 32'd1);
            check("to_pins", 32'({bus.tpa, bus.tpb, bus.nmrd, bus.nmwr, bus.db_oe, bus.busy}), 32'b001100);
            bus.nwait = 1'b1;
            repeat (4) @(negedge clk);
        end else if (act == 3) begin
            check("clr_err", 32'(bus.rsp_err), 32'd1);
            check("clr_delay_ok", 32'(c_done - c_trig >= 1 && c_done - c_trig <= SYNC_STAGES + 1), 32'd1);
            check("clr_pins", 32'({bus.tpa, bus.tpb, bus.nmrd, bus.nmwr, bus.db_oe, bus.busy}), 32'b001100);
            flag_a = 1'b0;
            flag_b = 1'b0;
            bus.req_valid = 1'b1;
            repeat (10) begin
                @(negedge clk);
                flag_a |= bus.req_ready;
                flag_b |= bus.rsp_valid;
            end
            bus.req_valid = 1'b0;
            check("clr_ready_low", 32'(flag_a), 32'd0);
            check("clr_no_rsp", 32'(flag_b), 32'd0);
            bus.clr = 1'b1;
            k = 0;
            while (!bus.req_ready && k < 10) begin
                @(negedge clk);
                k++;
            end
            check("clr_ready_back", 32'(bus.req_ready), 32'd1);
        end
    endtask

    initial begin
        logic        r_we;
        logic [15:0] r_a;
        logic [7:0]  r_d;
        resetn        = 1'b0;
        bus.nwait     = 1'b1;
        bus.clr       = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.db_di     = '0;
        hi_lat        = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h12A4] = 8'h5C;

        repeat (3) @(negedge clk);
        check("rst_bytes", 32'({bus.ma, bus.db_do, bus.rsp_rdata}), 32'd0);
        check("rst_bits", 32'({bus.tpa, bus.tpb, bus.nmrd, bus.nmwr, bus.db_oe,
                               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy}), 32'b001100000);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        run_cycle(1'b0, 16'h12A4, 8'h00, 0);
        run_cycle(1'b1, 16'h00FF, 8'h3C, 0);
        run_cycle(1'b0, 16'h00FF, 8'h00, 0);
        run_cycle(1'b0, 16'($urandom), 8'h00, 1);
        run_cycle(1'b0, 16'($urandom), 8'h00, 2);
        run_cycle(1'b1, 16'($urandom), 8'($urandom), 3);
        run_cycle(1'b0, 16'h4321, 8'h00, 4);
        repeat (4) @(negedge clk);
        run_cycle(1'b0, 16'h12A4, 8'h00, 0);

        for (int t = 0; t < 12; t++) begin
            r_we = 1'($urandom);
            r_a  = 16'($urandom);
            r_d  = 8'($urandom);
            run_cycle(r_we, r_a, r_d, ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
